// File: rtl/disp_source_arbiter_if.sv
// rtl/disp_source_arbiter_if.sv - source/display bundle between the sources and the display arbiter
//
// Purpose: groups the four source requests and values, the operator controls
// and the arbiter's registered grant/display outputs into one bundle.
// Signals:
//   req[3:0]        per-source display request, bit k = source k
//   data0..data3    16-bit source values
//   hold            level, freezes the dwell countdown
//   next            single-cycle pulse, forces advance to the next requester
//   grant[3:0]      one-hot current owner, 0 when idle
//   sel[1:0]        index of the current owner, keeps last value when idle
//   num_out[15:0]   registered value for the display driver
//   busy            high while a source owns the display
// Modports: master drives sources/controls, slave is the arbiter.
interface disp_source_arbiter_if;
    logic [3:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [15:0] data3;
    logic        hold;
    logic        next;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [15:0] num_out;
    logic        busy;

    modport master (
        output req, data0, data1, data2, data3, hold, next,
        input  grant, sel, num_out, busy
    );

    modport slave (
        input  req, data0, data1, data2, data3, hold, next,
        output grant, sel, num_out, busy
    );
endinterface

// File: rtl/disp_source_arbiter.sv
// rtl/disp_source_arbiter.sv - round-robin time-sharing of the 4-digit display between four sources
//
// Purpose: grants the display to one requesting source at a time in
// round-robin order, keeps each grant for DWELL cycles (frozen by hold,
// cut short by next or by the owner withdrawing) and registers the owner's
// value every cycle into num_out.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   disp_source_arbiter_if.slave (req, data0..3, hold, next in;
//         grant, sel, num_out, busy out)
// Parameters:
//   DWELL grant duration in clk cycles (1 .. 2^32-1)
//   CW    dwell counter width, derived from DWELL; leave at default
module disp_source_arbiter #(
    parameter int unsigned DWELL = 100_000_000,
    parameter int          CW    = $clog2(64'(DWELL) + 64'd1)
) (
    input  logic                  clk,
    input  logic                  rst,
    disp_source_arbiter_if.slave  bus
);

    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 32'd1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state, state_n;
    logic [3:0]    grant_q, grant_n;
    logic [1:0]    sel_q, sel_n;
    logic [1:0]    ptr_q, ptr_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [15:0]   num_q, num_n;

    // Returns {found, index}: first requester scanning start, start+1, ... mod 4.
    // The loop runs backwards so the lowest offset from start wins.
    function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = start + 2'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    function automatic logic [15:0] data_of(input logic [1:0] idx,
                                            input logic [15:0] d0, input logic [15:0] d1,
                                            input logic [15:0] d2, input logic [15:0] d3);
        case (idx)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return d3;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            num_q   <= 16'h0000;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            sel_q   <= sel_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
            num_q   <= num_n;
        end
    end

    logic [2:0] win;
    logic       rearb;

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        sel_n   = sel_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        num_n   = num_q;
        win     = 3'b000;
        rearb   = 1'b0;

        case (state)
            IDLE: begin
                win = search(bus.req, ptr_q);
                if (win[2]) begin
                    state_n = SHOW;
                    grant_n = 4'b0001 << win[1:0];
                    sel_n   = win[1:0];
                    ptr_n   = win[1:0] + 2'd1;
                    cnt_n   = RELOAD;
                end else begin
                    num_n = 16'h0000;
                end
            end
            default: begin
                // Withdrawal and next take precedence over hold; expiry only counts when not held.
                rearb = !bus.req[sel_q] || bus.next || (!bus.hold && cnt_q == '0);
                if (rearb) begin
                    win = search(bus.req, sel_q + 2'd1);
                    if (!win[2]) begin
                        state_n = IDLE;
                        grant_n = 4'b0000;
                    end else begin
                        // Sole requester re-wins itself: only the counter reloads.
                        cnt_n = RELOAD;
                        if (win[1:0] != sel_q) begin
                            grant_n = 4'b0001 << win[1:0];
                            sel_n   = win[1:0];
                            ptr_n   = win[1:0] + 2'd1;
                        end
                    end
                end else if (!bus.hold) begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
        endcase

        // num_out follows the owner chosen at this edge so withdrawn data never shows.
        if (state_n == SHOW)
            num_n = data_of(sel_n, bus.data0, bus.data1, bus.data2, bus.data3);
        else
            num_n = 16'h0000;
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.num_out = num_q;
    assign bus.busy    = (state == SHOW);

endmodule

// File: tb/tb_disp_source_arbiter.sv
// tb/tb_disp_source_arbiter.sv - self-checking bench for disp_source_arbiter
module tb_disp_source_arbiter;

    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] d [4];
    logic        hold;
    logic        nxt;

    int n_checks = 0;
    int n_pass   = 0;

    disp_source_arbiter_if bus ();

    assign bus.req   = req;
    assign bus.data0 = d[0];
    assign bus.data1 = d[1];
    assign bus.data2 = d[2];
    assign bus.data3 = d[3];
    assign bus.hold  = hold;
    assign bus.next  = nxt;

    disp_source_arbiter #(.DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: owner (-1 = idle), cycles of grant still remaining, rr pointer.
    int          m_owner = -1;
    int          m_rem   = 0;
    int          m_ptr   = 0;
    int          m_sel   = 0;
    logic [15:0] m_num   = 16'h0000;

    function automatic int pick(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_update();
        int  w;
        bit  sw;
        if (rst) begin
            m_owner = -1; m_rem = 0; m_ptr = 0; m_sel = 0; m_num = 16'h0000;
        end else if (m_owner < 0) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_rem = DWELL; m_ptr = (w + 1) % 4;
            end
        end else begin
            sw = !req[m_owner] || nxt || (!hold && m_rem == 1);
            if (sw) begin
                w = pick(req, (m_owner + 1) % 4);
                if (w < 0) begin
                    m_owner = -1;
                end else begin
                    m_rem = DWELL;
                    if (w != m_owner) begin
                        m_owner = w; m_sel = w; m_ptr = (w + 1) % 4;
                    end
                end
            end else if (!hold) begin
                m_rem = m_rem - 1;
            end
        end
        m_num = (m_owner < 0) ? 16'h0000 : d[m_owner];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("model_grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("model_sel", 32'(bus.sel), 32'(m_sel));
        chk("model_num", 32'(bus.num_out), 32'(m_num));
        chk("model_busy", 32'(bus.busy), 32'(m_owner >= 0));
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        hold;
        logic        nxt;
        logic [3:0]  g;
        logic [15:0] num;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] q, input logic h,
                                input logic n, input logic [3:0] g, input logic [15:0] num,
                                input int times);
        vec_t v;
        v.rst = r; v.req = q; v.hold = h; v.nxt = n; v.g = g; v.num = num;
        for (int i = 0; i < times; i++) tbl.push_back(v);
    endfunction

    task automatic expect_out(input string name, input logic [3:0] g, input logic [15:0] num);
        chk({name, "_grant"}, 32'(bus.grant), 32'(g));
        chk({name, "_num"}, 32'(bus.num_out), 32'(num));
        chk({name, "_busy"}, 32'(bus.busy), 32'(g != 4'b0000));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
        rst = 1'b1; req = 4'hF; hold = 1'b0; nxt = 1'b0;

        // reset, round-robin 1/3, sole requester, hold extension, next over hold
        add(1, 4'hF,    0, 0, 4'b0000, 16'h0000, 2);
        add(0, 4'hF,    0, 0, 4'b0001, 16'h1111, 1);
        add(0, 4'b1010, 0, 0, 4'b0010, 16'h2222, 4);
        add(0, 4'b1010, 0, 0, 4'b1000, 16'h4444, 4);
        add(0, 4'b1010, 0, 0, 4'b0010, 16'h2222, 1);
        add(0, 4'b0100, 0, 0, 4'b0100, 16'h3333, 9);
        add(0, 4'b0011, 0, 0, 4'b0001, 16'h1111, 1);
        add(0, 4'b0011, 1, 0, 4'b0001, 16'h1111, 10);
        add(0, 4'b0011, 0, 0, 4'b0001, 16'h1111, 3);
        add(0, 4'b0011, 0, 0, 4'b0010, 16'h2222, 1);
        add(0, 4'b0011, 1, 0, 4'b0010, 16'h2222, 1);
        add(0, 4'b0011, 1, 1, 4'b0001, 16'h1111, 1);
        add(0, 4'b0011, 1, 1, 4'b0010, 16'h2222, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; hold = tbl[i].hold; nxt = tbl[i].nxt;
            step();
            expect_out($sformatf("tbl%0d", i), tbl[i].g, tbl[i].num);
        end

        // withdrawal to source 0, then withdrawal to idle
        hold = 1'b0; nxt = 1'b0;
        req = 4'b0100; step(); expect_out("wd_own2", 4'b0100, 16'h3333);
        step();
        req = 4'b0101; step(); expect_out("wd_keep2", 4'b0100, 16'h3333);
        req = 4'b0001; step(); expect_out("wd_to0", 4'b0001, 16'h1111);
        req = 4'b0100; step(); expect_out("wd_back2", 4'b0100, 16'h3333);
        req = 4'b0000; step(); expect_out("wd_idle", 4'b0000, 16'h0000);
        step(); expect_out("idle_hold", 4'b0000, 16'h0000);

        // live data tracking then mid-grant reset
        req = 4'b0010; step(); expect_out("live_own1", 4'b0010, 16'h2222);
        d[1] = 16'hABCD; step(); expect_out("live_abcd", 4'b0010, 16'hABCD);
        rst = 1'b1; step(); expect_out("midrst", 4'b0000, 16'h0000);
        chk("midrst_sel", 32'(bus.sel), 32'd0);
        rst = 1'b0; d[1] = 16'h2222;

        // randomized run against the model
        for (int i = 0; i < 600; i++) begin
            req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0);
            nxt  = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 3)] = 16'($urandom);
            step();
            chk("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
